// File: rtl/matrix_addsub_param_pkg.sv
// matrix_addsub_param_pkg: shared helper for wrapping set-index counters
package matrix_addsub_param_pkg;
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/matrix_addsub_param_lanes.sv
// vector_addsub_lanes: per-lane sign-extended add/subtract with registered result and valid
module vector_addsub_lanes #(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 12,
  localparam int OW      = IN_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     valid_i,
  input  logic                     sub_i,
  input  logic [VEC_LEN*IN_WIDTH-1:0] a_i,
  input  logic [VEC_LEN*IN_WIDTH-1:0] b_i,
  output logic [VEC_LEN*OW-1:0]    s_o,
  output logic                     valid_o
);
  logic [VEC_LEN*OW-1:0] s_d, s_q;
  logic valid_q;
  for (genvar k = 0; k < VEC_LEN; k++) begin : g_lane
    logic [OW-1:0] a_x, b_x;
    assign a_x = {a_i[k*IN_WIDTH+IN_WIDTH-1], a_i[k*IN_WIDTH +: IN_WIDTH]};
    assign b_x = {b_i[k*IN_WIDTH+IN_WIDTH-1], b_i[k*IN_WIDTH +: IN_WIDTH]};
    assign s_d[k*OW +: OW] = sub_i ? a_x - b_x : a_x + b_x;
  end
  // result only loads on valid data so sVec keeps the last result between outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      valid_q <= 1'b0;
    end else if (enable) begin
      valid_q <= valid_i;
      if (valid_i) s_q <= s_d;
    end
  end
  assign s_o     = s_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/matrix_addsub_param.sv
// matrix_addsub_param: two-stage lane-parallel signed add/subtract with set and frame tracking
module matrix_addsub_param
  import matrix_addsub_param_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int VEC_LEN   = 12,
  parameter int NUM_SETS  = 10,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int OUT_WIDTH = IN_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         inReady,
  input  logic                         sub,
  input  logic [VEC_LEN*IN_WIDTH-1:0]  aVec,
  input  logic [VEC_LEN*IN_WIDTH-1:0]  bVec,
  output logic [SET_W-1:0]             vectorSetInNo,
  output logic                         earlyOutReady,
  output logic                         outReady,
  output logic [VEC_LEN*OUT_WIDTH-1:0] sVec,
  output logic [SET_W-1:0]             vectorSetOutNo,
  output logic                         frameDone
);
  localparam logic [SET_W-1:0] LAST = SET_W'(NUM_SETS - 1);
  logic [VEC_LEN*IN_WIDTH-1:0] a_q, b_q;
  logic sub_q, v1_q;
  logic [SET_W-1:0] in_no_d, in_no_q, out_no_d, out_no_q;
  // set counters step with accepted inputs and with data entering the output stage
  always_comb begin
    in_no_d  = (enable && inReady) ? SET_W'(next_idx(32'(in_no_q), 32'(NUM_SETS))) : in_no_q;
    out_no_d = (enable && v1_q) ? SET_W'(next_idx(32'(out_no_q), 32'(NUM_SETS))) : out_no_q;
  end
  // input register stage and counters; out index parks at the last set so the first output is 0
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      v1_q     <= 1'b0;
      in_no_q  <= '0;
      out_no_q <= LAST;
    end else begin
      in_no_q  <= in_no_d;
      out_no_q <= out_no_d;
      if (enable) begin
        a_q   <= aVec;
        b_q   <= bVec;
        sub_q <= sub;
        v1_q  <= inReady;
      end
    end
  end
  vector_addsub_lanes #(.IN_WIDTH(IN_WIDTH), .VEC_LEN(VEC_LEN)) u_lanes (
    .clk(clk), .reset(reset), .enable(enable), .valid_i(v1_q), .sub_i(sub_q),
    .a_i(a_q), .b_i(b_q), .s_o(sVec), .valid_o(outReady)
  );
  assign vectorSetInNo  = in_no_q;
  assign vectorSetOutNo = out_no_q;
  assign earlyOutReady  = v1_q;
  assign frameDone      = outReady && (out_no_q == LAST);
endmodule

// File: tb/tb_matrix_addsub_param.sv
// tb_matrix_addsub_param: directed table and corner-sequence checks for matrix_addsub_param
module tb_matrix_addsub_param;
  localparam int W = 16, L = 12, N = 10, OW = 17, SW = 4, T = 8;
  logic clk = 0, reset, enable, inReady, sub;
  logic [L*W-1:0] aVec, bVec;
  logic [L*OW-1:0] sVec;
  logic [SW-1:0] vectorSetInNo, vectorSetOutNo;
  logic earlyOutReady, outReady, frameDone;
  int checks = 0, errs = 0, fd_cnt;
  typedef struct { logic sub; int a; int b; int s; } vec_t;
  vec_t tbl[T];

  matrix_addsub_param #(.IN_WIDTH(W), .VEC_LEN(L), .NUM_SETS(N)) dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .sub(sub),
    .aVec(aVec), .bVec(bVec), .vectorSetInNo(vectorSetInNo), .earlyOutReady(earlyOutReady),
    .outReady(outReady), .sVec(sVec), .vectorSetOutNo(vectorSetOutNo), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [L*W-1:0] rep_in(input int v);
    logic [L*W-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [L*OW-1:0] rep_out(input int v);
    logic [L*OW-1:0] r;
    for (int k = 0; k < L; k++) r[k*OW +: OW] = OW'(v);
    return r;
  endfunction

  function automatic logic [L*W-1:0] fr_a(input int i);
    logic [L*W-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = W'(i * 16 + k);
    return r;
  endfunction

  function automatic logic [L*W-1:0] fr_b(input int i);
    logic [L*W-1:0] r;
    for (int k = 0; k < L; k++) r[k*W +: W] = W'(3 * k - i);
    return r;
  endfunction

  function automatic logic [L*OW-1:0] fr_s(input int i);
    logic [L*OW-1:0] r;
    for (int k = 0; k < L; k++) r[k*OW +: OW] = OW'((i % 2) ? (i * 16 + k) - (3 * k - i) : (i * 16 + k) + (3 * k - i));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [L*W-1:0] a, input logic [L*W-1:0] b);
    inReady = 1;
    sub = s;
    aVec = a;
    bVec = b;
  endtask

  task automatic rst_pulse();
    reset = 1;
    inReady = 0;
    step();
    reset = 0;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [L*OW-1:0] act, input logic [L*OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0,  32767,  32767,  65534};
    tbl[1] = '{1'b1, -32768,  32767, -65535};
    tbl[2] = '{1'b0, -32768,  32767,     -1};
    tbl[3] = '{1'b1,  32767, -32768,  65535};
    tbl[4] = '{1'b0, -32768, -32768, -65536};
    tbl[5] = '{1'b1,      0,      0,      0};
    tbl[6] = '{1'b1,    100,    250,   -150};
    tbl[7] = '{1'b0,     -5,      3,     -2};
    reset = 1; enable = 1; inReady = 0; sub = 0; aVec = '0; bVec = '0;
    step();
    step();
    chk("rst_in_no", vectorSetInNo, 0);
    chk("rst_out_no", vectorSetOutNo, N - 1);
    chk("rst_out_rdy", outReady, 0);
    chk("rst_early", earlyOutReady, 0);
    chk("rst_frame", frameDone, 0);
    chkv("rst_svec", sVec, '0);
    reset = 0;
    for (int i = 0; i <= T; i++) begin
      if (i < T) drive(tbl[i].sub, rep_in(tbl[i].a), rep_in(tbl[i].b));
      else inReady = 0;
      step();
      chk("tbl_early", earlyOutReady, (i < T) ? 1 : 0);
      if (i >= 1) begin
        chk("tbl_out_rdy", outReady, 1);
        chkv("tbl_svec", sVec, rep_out(tbl[i-1].s));
        chk("tbl_out_no", vectorSetOutNo, i - 1);
      end
    end
    step();
    chk("hold_out_rdy", outReady, 0);
    chkv("hold_svec", sVec, rep_out(tbl[T-1].s));
    chk("hold_in_no", vectorSetInNo, T);
    chk("hold_out_no", vectorSetOutNo, T - 1);
    rst_pulse();
    fd_cnt = 0;
    for (int i = 0; i <= N; i++) begin
      if (i < N) drive(logic'(i % 2), fr_a(i), fr_b(i));
      else inReady = 0;
      step();
      fd_cnt += int'(frameDone);
      if (i >= 1) begin
        chk("frm_out_rdy", outReady, 1);
        chk("frm_out_no", vectorSetOutNo, i - 1);
        chk("frm_done", frameDone, (i == N) ? 1 : 0);
        chkv("frm_svec", sVec, fr_s(i - 1));
      end
    end
    step();
    fd_cnt += int'(frameDone);
    chk("frm_done_cnt", fd_cnt, 1);
    chk("frm_in_no_wrap", vectorSetInNo, 0);
    rst_pulse();
    drive(0, rep_in(10), rep_in(5));
    step();
    drive(1, rep_in(10), rep_in(5));
    step();
    enable = 0;
    drive(0, rep_in(999), rep_in(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_out_rdy", outReady, 1);
      chkv("frz_svec", sVec, rep_out(15));
      chk("frz_out_no", vectorSetOutNo, 0);
      chk("frz_in_no", vectorSetInNo, 2);
      chk("frz_early", earlyOutReady, 1);
    end
    enable = 1;
    inReady = 0;
    step();
    chk("res_out_rdy", outReady, 1);
    chkv("res_svec", sVec, rep_out(5));
    chk("res_out_no", vectorSetOutNo, 1);
    chk("res_early", earlyOutReady, 0);
    step();
    chk("res_done_rdy", outReady, 0);
    chk("res_in_no", vectorSetInNo, 2);
    chkv("res_hold", sVec, rep_out(5));
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      drive(0, rep_in(i), rep_in(i));
      step();
    end
    chk("mid_pre_out_no", vectorSetOutNo, 3);
    rst_pulse();
    chk("mid_out_rdy", outReady, 0);
    chk("mid_early", earlyOutReady, 0);
    chk("mid_in_no", vectorSetInNo, 0);
    chk("mid_out_no", vectorSetOutNo, N - 1);
    chkv("mid_svec", sVec, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", outReady, 0);
    end
    drive(1, rep_in(7), rep_in(2));
    step();
    inReady = 0;
    step();
    chk("post_out_rdy", outReady, 1);
    chk("post_out_no", vectorSetOutNo, 0);
    chkv("post_svec", sVec, rep_out(5));
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
